// File: rtl/bcd_ascii_tx.sv
// Serializes a packed BCD word as ASCII decimal text, most-significant digit first,
// with optional leading-zero blanking and a CR/LF terminator, over valid/ready handshakes.
module bcd_ascii_tx #(
    parameter int BITS        = 18,
    parameter bit LZ_BLANK    = 1'b1,
    parameter bit APPEND_CRLF = 1'b1,
    localparam int BCD_W      = BITS + (BITS - 4) / 3 + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BCD_W-1:0] bcd_in,
    input  logic             bcd_valid,
    output logic             bcd_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy
);

    localparam int DIGITS = (BCD_W + 3) / 4;
    localparam int WORD_W = DIGITS * 4;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIGIT = 2'd1,
        S_CR    = 2'd2,
        S_LF    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [WORD_W-1:0]  word_in_s;
    logic               hs_s;
    logic               cap_s;

    function automatic logic [3:0] digit_of(input logic [WORD_W-1:0] w, input logic [IDX_W-1:0] idx);
        logic [3:0] d;
        d = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == idx) begin
                d = w[k*4 +: 4];
            end else begin
                d = d;
            end
        end
        return d;
    endfunction

    // Highest nonzero digit position; zero when the whole word is zero.
    function automatic logic [IDX_W-1:0] top_digit(input logic [WORD_W-1:0] w);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w[k*4 +: 4] != 4'h0) begin
                r = IDX_W'(k);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] ascii_of(input logic [3:0] d);
        logic [7:0] a;
        if (d <= 4'd9) begin
            a = 8'h30 + {4'h0, d};
        end else begin
            a = 8'h3F;
        end
        return a;
    endfunction

    assign word_in_s = WORD_W'(bcd_in);
    assign hs_s      = valid_q && tx_ready;
    assign cap_s     = bcd_valid && ready_q;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                if (cap_s) begin
                    word_d  = word_in_s;
                    idx_d   = LZ_BLANK ? top_digit(word_in_s) : IDX_TOP;
                    state_d = S_DIGIT;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_DIGIT: begin
                // The capture cycle only loads the word; the first byte appears one cycle later.
                if (!valid_q) begin
                    valid_d = 1'b1;
                    data_d  = ascii_of(digit_of(word_q, idx_q));
                end else if (tx_ready) begin
                    if (idx_q != '0) begin
                        idx_d  = idx_q - IDX_ONE;
                        data_d = ascii_of(digit_of(word_q, idx_q - IDX_ONE));
                    end else if (APPEND_CRLF) begin
                        state_d = S_CR;
                        data_d  = 8'h0D;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_CR: begin
                if (hs_s) begin
                    state_d = S_LF;
                    data_d  = 8'h0A;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_LF: begin
                if (hs_s) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign bcd_ready = ready_q;
    assign tx_data   = data_q;
    assign tx_valid  = valid_q;
    assign busy      = busy_q;

endmodule
